debug_dump_seq: RTL
===================

Name: debug_dump_seq

Overview:
Parametrised dump sequencer for the debug path. It is the successor to the fixed PC/register/memory send logic that sits between the pipeline and the UART TX. After a start pulse (halt or step complete), it serialises the selected debug words into bytes over a start/done handshake with the UART transmitter. Generalised in word width, register count, memory depth and dump mode.

Parameters:
NB_DATA, 32, debug word width; must be a multiple of N_BITS
N_BITS, 8, UART byte width
N_REGS, 32, registers dumped (indices 0..N_REGS-1)
NB_REG, 5, register address width, clog2(N_REGS)
N_MEM_WORDS, 32, data memory words dumped (addresses 0..N_MEM_WORDS-1)
NB_MEM_ADDR, 5, memory address width, clog2(N_MEM_WORDS)

Ports:
i_clock  in  1  single clock
i_reset  in  1  synchronous reset, active-high
i_start  in  1  one-cycle dump request
i_mode  in  2  00 full, 01 regs only, 10 mem only, 11 PC+cycles only; sampled on accepted i_start
i_pc  in  NB_DATA  program counter, sampled on accepted i_start
i_cycles  in  NB_DATA  cycle count, sampled on accepted i_start
i_reg_data  in  NB_DATA  register file read data, valid 1 cycle after o_reg_rd
i_mem_data  in  NB_DATA  memory read data, valid 1 cycle after o_mem_rd
i_tx_done  in  1  UART TX finished current byte (pulse)
o_reg_addr  out  NB_REG  register read address
o_reg_rd  out  1  register read strobe
o_mem_addr  out  NB_MEM_ADDR  memory read address
o_mem_rd  out  1  memory read strobe
o_tx_data  out  N_BITS  byte to send, held stable from o_tx_start until i_tx_done
o_tx_start  out  1  one-cycle TX start pulse
o_busy  out  1  high from the cycle after accepted i_start until o_done
o_done  out  1  one-cycle pulse when the last byte's i_tx_done is seen

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters and checksum cleared. Reset mid-dump aborts with no o_done pulse.
- BYTES = NB_DATA/N_BITS. Each word is sent least-significant byte first.
- Sequence by mode:
  - full: PC, cycles, reg 0..N_REGS-1, mem 0..N_MEM_WORDS-1
  - regs: reg 0..N_REGS-1 only
  - mem: mem 0..N_MEM_WORDS-1 only
  - PC+cycles: PC, cycles only
- FSM states:
  - IDLE: on i_start, latch mode, PC and cycles, then go to SELECT. i_start while not IDLE is ignored.
  - SELECT: choose the next word source. PC/cycles use the latched values and go directly to SEND. A register or memory word goes to READ.
  - READ: drive the address and assert the strobe for 1 cycle.
  - CAPTURE: the next cycle; register i_*_data into the shift register.
  - SEND: o_tx_start=1 for 1 cycle; o_tx_data = shift[N_BITS-1:0].
  - WAIT_TX: wait for i_tx_done, then shift right by N_BITS. If bytes remain, return to SEND. Else if words remain, return to SELECT. Else go to FINISH.
  - FINISH: o_done=1 for 1 cycle; o_busy drops in the same cycle; return to IDLE.
- Latency from accepted i_start to the first o_tx_start:
  - 2 cycles for PC-first modes
  - 4 cycles for register- or memory-first modes
- Handshake rules:
  - i_tx_done outside WAIT_TX is ignored.
  - i_tx_done can never be accepted in the same cycle as o_tx_start; the earliest accepted done is the following cycle.
- Counters: each counter is sized to its address width and stops at its last index (N_REGS-1 or N_MEM_WORDS-1); no wrap.
- Address outputs hold their last value when idle.
- i_pc and i_cycles changing during a dump have no effect.

Optional Feature:
Macro DUMP_CHECKSUM_EN.
- Defined: a running XOR of all sent bytes is kept. After the last data byte, one extra byte equal to that XOR is sent, then FINISH.
- Undefined: no checksum byte; the dump ends after the last data byte.

Decomposition:
- Shared package/header debug_dump_pkg.vh:
  - mode encodings DUMP_FULL, DUMP_REGS, DUMP_MEM, DUMP_PCCYC
  - FSM state encodings
  - BYTES derivation
- One natural sub-module: word_serializer (load NB_DATA word, emit BYTES bytes with start/done handshake). The top FSM sequences word sources around it.

Test Plan:
- Bench setup: TX model returns i_tx_done 3 cycles after each o_tx_start.
- mode=11, PC=0x00000010, cycles=0x0000012C -> bytes 10 00 00 00 2C 01 00 00, then o_done; no o_reg_rd/o_mem_rd.
- mode=01, reg[k]=k*0x01010101 -> 128 bytes; reg 31 sends 1F 1F 1F 1F; o_reg_addr steps 0..31; o_done once.
- mode=00 full dump -> 8+128+128 = 264 bytes in PC, cycles, regs, mem order; first o_tx_start exactly 2 cycles after i_start.
- i_start re-pulsed mid-dump plus spurious i_tx_done in SEND/IDLE -> both ignored, byte stream unchanged.
- i_reset asserted in WAIT_TX of byte 5 -> next cycle all outputs 0 and no o_done; a new i_start restarts from byte 0.
- DUMP_CHECKSUM_EN, mode=11 with above values -> extra byte 0x3D (XOR of the 8 bytes), then o_done.

Source files
------------

// File: rtl/debug_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module  : debug_dump_pkg
// Brief   : Shared encodings for the debug dump sequencer (modes, FSM states,
//           word sources) and byte-count helpers.
// Rev     : 1.0 - initial release
// ============================================================================
package debug_dump_pkg;

    localparam logic [1:0] DUMP_FULL  = 2'b00;
    localparam logic [1:0] DUMP_REGS  = 2'b01;
    localparam logic [1:0] DUMP_MEM   = 2'b10;
    localparam logic [1:0] DUMP_PCCYC = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_READ    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;
    localparam logic [2:0] ST_CHKSUM  = 3'd6;
    localparam logic [2:0] ST_FINISH  = 3'd7;

    localparam logic [1:0] SRC_PC  = 2'd0;
    localparam logic [1:0] SRC_CYC = 2'd1;
    localparam logic [1:0] SRC_REG = 2'd2;
    localparam logic [1:0] SRC_MEM = 2'd3;

    function automatic int calc_bytes(input int nb_data, input int n_bits);
        return nb_data / n_bits;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// Module  : word_serializer
// Brief   : Loads one NB_DATA word and presents it LSB byte first, advancing
//           one byte per i_shift.
// Rev     : 1.0 - initial release
// ============================================================================
module word_serializer
    import debug_dump_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int N_BITS  = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_shift,
    output logic [N_BITS-1:0]  o_byte,
    output logic               o_last
);

    localparam int BYTES = calc_bytes(NB_DATA, N_BITS);
    localparam int CW    = cnt_width(BYTES);

    logic [NB_DATA-1:0] r_shift;
    logic [CW-1:0]      r_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shift <= r_shift >> N_BITS;
            if (!o_last)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_byte = r_shift[N_BITS-1:0];
    assign o_last = (r_cnt == CW'(BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/debug_dump_seq.sv
`default_nettype none
// ============================================================================
// Module  : debug_dump_seq
// Brief   : Debug dump sequencer: serialises PC, cycles, registers and memory
//           words to the UART TX. Optional trailing XOR byte: DUMP_CHECKSUM_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module debug_dump_seq
    import debug_dump_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int N_BITS      = 8,
    parameter int N_REGS      = 32,
    parameter int NB_REG      = 5,
    parameter int N_MEM_WORDS = 32,
    parameter int NB_MEM_ADDR = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [1:0]             i_mode,
    input  logic [NB_DATA-1:0]     i_pc,
    input  logic [NB_DATA-1:0]     i_cycles,
    input  logic [NB_DATA-1:0]     i_reg_data,
    input  logic [NB_DATA-1:0]     i_mem_data,
    input  logic                   i_tx_done,
    output logic [NB_REG-1:0]      o_reg_addr,
    output logic                   o_reg_rd,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    output logic                   o_mem_rd,
    output logic [N_BITS-1:0]      o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [NB_REG-1:0]      c_REG_LAST = NB_REG'(N_REGS - 1);
    localparam logic [NB_MEM_ADDR-1:0] c_MEM_LAST = NB_MEM_ADDR'(N_MEM_WORDS - 1);
`ifdef DUMP_CHECKSUM_EN
    localparam logic [2:0] c_ST_AFTER_DATA = ST_CHKSUM;
`else
    localparam logic [2:0] c_ST_AFTER_DATA = ST_FINISH;
`endif

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [1:0]             r_mode;
    logic [1:0]             r_src;
    logic [NB_DATA-1:0]     r_pc;
    logic [NB_DATA-1:0]     r_cycles;
    logic [NB_REG-1:0]      r_reg_addr;
    logic [NB_MEM_ADDR-1:0] r_mem_addr;
    logic                   w_start_ok;
    logic                   w_tx_ack;
    logic                   w_more;
    logic                   w_ser_load;
    logic                   w_ser_last;
    logic [NB_DATA-1:0]     w_ser_word;
    logic [N_BITS-1:0]      w_ser_byte;
`ifdef DUMP_CHECKSUM_EN
    logic [N_BITS-1:0]      r_csum;
    logic                   r_csum_phase;
`endif

    assign w_start_ok = (r_state == ST_IDLE) && i_start;
    assign w_tx_ack   = (r_state == ST_WAIT_TX) && i_tx_done;

    // Whether another word follows the current source/index in this mode.
    always_comb begin
        w_more = 1'b0;
        case (r_src)
            SRC_PC:  w_more = 1'b1;
            SRC_CYC: w_more = (r_mode == DUMP_FULL);
            SRC_REG: w_more = (r_reg_addr != c_REG_LAST) || (r_mode == DUMP_FULL);
            default: w_more = (r_mem_addr != c_MEM_LAST);
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_next = ST_SELECT;
            ST_SELECT:  w_next = ((r_src == SRC_PC) || (r_src == SRC_CYC)) ? ST_SEND : ST_READ;
            ST_READ:    w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_SEND;
            ST_SEND:    w_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    if (!w_ser_last)
                        w_next = ST_SEND;
                    else if (w_more)
                        w_next = ST_SELECT;
                    else
                        w_next = c_ST_AFTER_DATA;
`ifdef DUMP_CHECKSUM_EN
                    if (r_csum_phase)
                        w_next = ST_FINISH;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CHKSUM:  w_next = ST_SEND;
`endif
            ST_FINISH:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_reg_addr = r_reg_addr;
        o_mem_addr = r_mem_addr;
        o_reg_rd   = (r_state == ST_READ) && (r_src == SRC_REG);
        o_mem_rd   = (r_state == ST_READ) && (r_src == SRC_MEM);
        o_tx_start = (r_state == ST_SEND);
        o_tx_data  = w_ser_byte;
        o_busy     = (r_state != ST_IDLE) && (r_state != ST_FINISH);
        o_done     = (r_state == ST_FINISH);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mode       <= DUMP_FULL;
            r_src        <= SRC_PC;
            r_pc         <= '0;
            r_cycles     <= '0;
            r_reg_addr   <= '0;
            r_mem_addr   <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_csum       <= '0;
            r_csum_phase <= 1'b0;
`endif
        end else begin
            if (w_start_ok) begin
                r_mode     <= i_mode;
                r_pc       <= i_pc;
                r_cycles   <= i_cycles;
                r_reg_addr <= '0;
                r_mem_addr <= '0;
                case (i_mode)
                    DUMP_REGS: r_src <= SRC_REG;
                    DUMP_MEM:  r_src <= SRC_MEM;
                    default:   r_src <= SRC_PC;
                endcase
`ifdef DUMP_CHECKSUM_EN
                r_csum       <= '0;
                r_csum_phase <= 1'b0;
`endif
            end
            // Advance to the next word once the last byte of this one is acknowledged.
            if (w_tx_ack && w_ser_last && w_more) begin
                case (r_src)
                    SRC_PC:  r_src <= SRC_CYC;
                    SRC_CYC: r_src <= SRC_REG;
                    SRC_REG: begin
                        if (r_reg_addr != c_REG_LAST)
                            r_reg_addr <= r_reg_addr + 1'b1;
                        else
                            r_src <= SRC_MEM;
                    end
                    default: r_mem_addr <= r_mem_addr + 1'b1;
                endcase
            end
`ifdef DUMP_CHECKSUM_EN
            if (w_tx_ack && !r_csum_phase)
                r_csum <= r_csum ^ w_ser_byte;
            if (r_state == ST_CHKSUM)
                r_csum_phase <= 1'b1;
`endif
        end
    end

    always_comb begin
        w_ser_load = ((r_state == ST_SELECT) && ((r_src == SRC_PC) || (r_src == SRC_CYC)))
                   || (r_state == ST_CAPTURE);
`ifdef DUMP_CHECKSUM_EN
        if (r_state == ST_CHKSUM)
            w_ser_load = 1'b1;
`endif
        w_ser_word = r_pc;
        case (r_state)
            ST_CAPTURE: w_ser_word = (r_src == SRC_REG) ? i_reg_data : i_mem_data;
`ifdef DUMP_CHECKSUM_EN
            ST_CHKSUM:  w_ser_word = NB_DATA'(r_csum);
`endif
            default:    w_ser_word = (r_src == SRC_CYC) ? r_cycles : r_pc;
        endcase
    end

    word_serializer #(
        .NB_DATA (NB_DATA),
        .N_BITS  (N_BITS)
    ) u_ser (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_ser_load),
        .i_word  (w_ser_word),
        .i_shift (w_tx_ack),
        .o_byte  (w_ser_byte),
        .o_last  (w_ser_last)
    );

endmodule
`default_nettype wire
